// File: rtl/tstate_sequencer_pkg.sv
// Shared T-state one-hot constants, interrupt-source encodings and the BRK opcode
// for the 6502C instruction sequencer.
package tstate_sequencer_pkg;

  localparam int unsigned T_W = 7;

  localparam logic [6:0] T0 = 7'b0000001;
  localparam logic [6:0] T1 = 7'b0000010;
  localparam logic [6:0] T2 = 7'b0000100;
  localparam logic [6:0] T3 = 7'b0001000;
  localparam logic [6:0] T4 = 7'b0010000;
  localparam logic [6:0] T5 = 7'b0100000;
  localparam logic [6:0] T6 = 7'b1000000;

  localparam logic [1:0] INT_NONE  = 2'd0;
  localparam logic [1:0] INT_IRQ   = 2'd1;
  localparam logic [1:0] INT_NMI   = 2'd2;
  localparam logic [1:0] INT_RESET = 2'd3;

  localparam logic [7:0] BRK_OP_DEF = 8'h00;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_JAM = 1'b1
  } seq_state_e;

  // x/z anywhere makes the result x, which callers must treat as "not one-hot".
  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/tstate_sequencer_nmi_edge_det.sv
// NMI falling-edge detector with a sticky pending flag; the edge is also passed
// straight through so an edge in a boundary cycle is seen by that boundary.
module nmi_edge_det (
  input  logic phi2,
  input  logic rst,
  input  logic nmi_n,
  input  logic clear,
  output logic nmi_pend
);

  logic r_prev;
  logic r_pend;
  logic w_edge;

  assign w_edge = r_prev & ~nmi_n;

  always_ff @(posedge phi2) begin
    if (rst) begin
      r_prev <= 1'b1;
      r_pend <= 1'b0;
    end else begin
      r_prev <= nmi_n;
      // A new edge outranks a clear issued in the same cycle.
      if (w_edge) begin
        r_pend <= 1'b1;
      end else if (clear) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign nmi_pend = r_pend | w_edge;

endmodule

// File: rtl/tstate_sequencer.sv
// 6502C instruction register and T-state sequencer: registers the decoder's next-T,
// injects BRK for reset/NMI/IRQ at boundaries, jams on an illegal T-state until reset.
module tstate_sequencer
  import tstate_sequencer_pkg::*;
#(
  parameter logic [7:0] BRK_OP = BRK_OP_DEF
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] db_in,
  input  logic [6:0] next_t,
  input  logic       status_i,
  input  logic       nmi_n,
  input  logic       irq_n,
  output logic [7:0] opcode,
  output logic [6:0] curr_t,
  output logic       sync,
  output logic [1:0] int_kind,
  output logic       pc_inc_sup,
  output logic       jam
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [7:0] r_ir;
  logic [6:0] r_t;
  logic [1:0] r_int;
  logic       r_rst_pend;

  logic [7:0] w_ir_nxt;
  logic [6:0] w_t_nxt;
  logic [1:0] w_int_nxt;
  logic       w_rst_pend_nxt;
  logic       w_nmi_clr;
  logic       w_illegal;
  logic       w_nmi_pend;
  logic       w_irq_req;

  nmi_edge_det u_nmi (
    .phi2     (phi2),
    .rst      (rst),
    .nmi_n    (nmi_n),
    .clear    (w_nmi_clr),
    .nmi_pend (w_nmi_pend)
  );

  assign w_irq_req = ~irq_n & ~status_i;

  // FSM state register
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && w_illegal) begin
      w_state_nxt = ST_JAM;
    end
  end

  // FSM outputs
  always_comb begin
    jam = (r_state == ST_JAM);
  end

  // Sequencing datapath: everything holds unless running with rdy high.
  always_comb begin
    w_ir_nxt       = r_ir;
    w_t_nxt        = r_t;
    w_int_nxt      = r_int;
    w_rst_pend_nxt = r_rst_pend;
    w_nmi_clr      = 1'b0;
    w_illegal      = 1'b0;
    if (r_state == ST_RUN && rdy) begin
      if (r_t == T1) begin
        w_ir_nxt = (r_int != INT_NONE) ? BRK_OP : db_in;
        w_t_nxt  = T2;
      end else if (is_onehot7(next_t)) begin
        w_t_nxt = next_t;
        if (next_t == T1) begin
          if (r_rst_pend) begin
            w_int_nxt      = INT_RESET;
            w_rst_pend_nxt = 1'b0;
          end else if (w_nmi_pend) begin
            w_int_nxt = INT_NMI;
            w_nmi_clr = 1'b1;
          end else if (w_irq_req) begin
            w_int_nxt = INT_IRQ;
          end else begin
            w_int_nxt = INT_NONE;
          end
        end
      end else begin
        w_illegal = 1'b1;
      end
    end
  end

  // Reset leaves the reset injection already latched, so the first T1 fetches BRK.
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_ir       <= 8'h00;
      r_t        <= T1;
      r_int      <= INT_RESET;
      r_rst_pend <= 1'b0;
    end else begin
      r_ir       <= w_ir_nxt;
      r_t        <= w_t_nxt;
      r_int      <= w_int_nxt;
      r_rst_pend <= w_rst_pend_nxt;
    end
  end

  assign opcode     = r_ir;
  assign curr_t     = r_t;
  assign sync       = (r_t == T1);
  assign int_kind   = r_int;
  assign pc_inc_sup = (r_int != INT_NONE);

endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed bench for tstate_sequencer: the bench plays the decoder by driving next_t
// each cycle and checks IR/T-state/interrupt outputs one cycle after each edge.
module tb_tstate_sequencer;

  localparam logic [6:0] T1 = 7'b0000010;
  localparam logic [6:0] T2 = 7'b0000100;
  localparam logic [6:0] T3 = 7'b0001000;
  localparam logic [6:0] T4 = 7'b0010000;

  logic       phi2;
  logic       rst;
  logic       rdy;
  logic [7:0] db_in;
  logic [6:0] next_t;
  logic       status_i;
  logic       nmi_n;
  logic       irq_n;
  logic [7:0] opcode;
  logic [6:0] curr_t;
  logic       sync;
  logic [1:0] int_kind;
  logic       pc_inc_sup;
  logic       jam;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  tstate_sequencer #(.BRK_OP(8'h00)) dut (
    .phi2       (phi2),
    .rst        (rst),
    .rdy        (rdy),
    .db_in      (db_in),
    .next_t     (next_t),
    .status_i   (status_i),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .opcode     (opcode),
    .curr_t     (curr_t),
    .sync       (sync),
    .int_kind   (int_kind),
    .pc_inc_sup (pc_inc_sup),
    .jam        (jam)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".opcode"},   32'(opcode),     32'h00);
    chk({tag, ".curr_t"},   32'(curr_t),     32'(T1));
    chk({tag, ".sync"},     32'(sync),       32'd1);
    chk({tag, ".int_kind"}, 32'(int_kind),   32'd3);
    chk({tag, ".pc_inc"},   32'(pc_inc_sup), 32'd1);
    chk({tag, ".jam"},      32'(jam),        32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; db_in = 8'h00; next_t = T2;
    status_i = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");

    // Reset BRK: T1 fetch must inject 00 even though the bus carries EA.
    rst = 1'b0; db_in = 8'hEA;
    tick();
    chk("rstbrk.opcode", 32'(opcode), 32'h00);
    chk("rstbrk.curr_t", 32'(curr_t), 32'(T2));
    chk("rstbrk.sync",   32'(sync),   32'd0);
    chk("rstbrk.kind",   32'(int_kind), 32'd3);
    next_t = T1;
    tick();
    chk("rstbrk.end.t",    32'(curr_t),     32'(T1));
    chk("rstbrk.end.kind", 32'(int_kind),   32'd0);
    chk("rstbrk.end.pc",   32'(pc_inc_sup), 32'd0);

    // LDA #imm
    db_in = 8'hA9; next_t = T3;
    tick();
    chk("lda.opcode", 32'(opcode), 32'hA9);
    chk("lda.t2",     32'(curr_t), 32'(T2));
    chk("lda.sync0",  32'(sync),   32'd0);
    next_t = T1;
    tick();
    chk("lda.t1",   32'(curr_t),   32'(T1));
    chk("lda.sync", 32'(sync),     32'd1);
    chk("lda.kind", 32'(int_kind), 32'd0);

    // IRQ unmasked at the boundary
    tick();
    irq_n = 1'b0; status_i = 1'b0; next_t = T1;
    tick();
    chk("irq.kind", 32'(int_kind),   32'd1);
    chk("irq.pc",   32'(pc_inc_sup), 32'd1);
    db_in = 8'h55;
    tick();
    chk("irq.opcode", 32'(opcode), 32'h00);
    chk("irq.t2",     32'(curr_t), 32'(T2));

    // IRQ masked by I flag
    status_i = 1'b1; next_t = T1;
    tick();
    chk("irqm.kind", 32'(int_kind), 32'd0);
    tick();
    chk("irqm.opcode", 32'(opcode),     32'h55);
    chk("irqm.pc",     32'(pc_inc_sup), 32'd0);

    // NMI edge two cycles before the boundary beats a pending unmasked IRQ
    status_i = 1'b0; irq_n = 1'b0; nmi_n = 1'b0; next_t = T3;
    tick();
    chk("nmi.t3", 32'(curr_t), 32'(T3));
    next_t = T1;
    tick();
    chk("nmi.kind", 32'(int_kind), 32'd2);
    nmi_n = 1'b1; db_in = 8'h77;
    tick();
    chk("nmi.opcode", 32'(opcode), 32'h00);
    next_t = T1;
    tick();
    chk("nmi.next.kind", 32'(int_kind), 32'd1);
    irq_n = 1'b1;
    tick();
    chk("nmi.irqbrk.op", 32'(opcode), 32'h00);
    next_t = T1;
    tick();
    chk("nmi.done.kind", 32'(int_kind), 32'd0);

    // Stall in T3
    db_in = 8'h8D;
    tick();
    chk("stall.opcode0", 32'(opcode), 32'h8D);
    next_t = T3;
    tick();
    chk("stall.t3", 32'(curr_t), 32'(T3));
    rdy = 1'b0; next_t = T4; db_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.hold.t", 32'(curr_t), 32'(T3));
    end
    chk("stall.hold.op",   32'(opcode),   32'h8D);
    chk("stall.hold.kind", 32'(int_kind), 32'd0);
    rdy = 1'b1;
    tick();
    chk("stall.resume", 32'(curr_t), 32'(T4));
    next_t = T1;
    tick();
    chk("stall.boundary", 32'(curr_t), 32'(T1));

    // Jam on a two-hot next_t in T2
    db_in = 8'hA9;
    tick();
    next_t = 7'b0000110;
    tick();
    chk("jam.set", 32'(jam),    32'd1);
    chk("jam.t",   32'(curr_t), 32'(T2));
    chk("jam.op",  32'(opcode), 32'hA9);
    next_t = T1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("jam.hold", 32'(jam), 32'd1);
    end
    chk("jam.hold.t", 32'(curr_t), 32'(T2));
    rst = 1'b1;
    tick();
    chk_reset_vals("jamrst");
    rst = 1'b0;

    // Reset at T4 of a longer instruction
    tick();
    next_t = T1;
    tick();
    chk("mid.pre.kind", 32'(int_kind), 32'd0);
    db_in = 8'h6D; next_t = T3;
    tick();
    tick();
    next_t = T4;
    tick();
    chk("mid.t4", 32'(curr_t), 32'(T4));
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    chk("mid.brk.op",   32'(opcode),   32'h00);
    chk("mid.brk.kind", 32'(int_kind), 32'd3);
    chk("mid.brk.t",    32'(curr_t),   32'(T2));

    // NMI edge in the boundary cycle itself is taken at that boundary
    next_t = T1;
    tick();
    db_in = 8'hEA;
    tick();
    nmi_n = 1'b0; next_t = T1;
    tick();
    chk("nmib.kind", 32'(int_kind), 32'd2);
    nmi_n = 1'b1;
    tick();

    // Unknown next_t is illegal
    next_t = 7'bxxxxxxx;
    tick();
    chk("jamx.set", 32'(jam), 32'd1);
    next_t = T1; rst = 1'b1;
    tick();
    chk("jamx.rst", 32'(jam), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
